// File: rtl/wc_z_serializer.sv
// wc_z_serializer: 2-slot ping-pong buffer that streams each NW-word result frame one DW-bit word per cycle.
// Optional: define WC_SER_CKSUM_EN to append an XOR checksum word to every frame.
module wc_z_serializer #(
    parameter int DW = 10,
    parameter int NW = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW*NW-1:0] z_in,
    input  logic             z_valid,
    output logic             z_ready,
    output logic [DW-1:0]    s_data,
    output logic             s_valid,
    output logic             s_sof,
    output logic             s_eof,
    input  logic             s_ready,
    output logic             ovf
);
`ifdef WC_SER_CKSUM_EN
    localparam int NWO = NW + 1;
`else
    localparam int NWO = NW;
`endif
    localparam int IW = $clog2(NWO);
    logic [DW*NW-1:0] slot_q [2];
    logic [DW*NW-1:0] slot_d [2];
    logic [1:0]       count_q, count_d;
    logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             ovf_q, ovf_d;
    logic [DW-1:0]    s_data_q, s_data_d;
    logic             s_valid_q, s_valid_d, s_sof_q, s_sof_d, s_eof_q, s_eof_d;
    logic             acc, xfer, last;
    logic [DW-1:0]    words [NWO];
`ifdef WC_SER_CKSUM_EN
    logic [DW-1:0]    cksum_q [2];
    logic [DW-1:0]    cksum_d [2];
    logic [DW-1:0]    z_x;
`endif

    assign z_ready = (count_q != 2'd2);
    assign s_data  = s_data_q;
    assign s_valid = s_valid_q;
    assign s_sof   = s_sof_q;
    assign s_eof   = s_eof_q;
    assign ovf     = ovf_q;

    // Next state for buffer/pointers; outputs are precomputed from next state so they register cleanly.
    always_comb begin
        slot_d   = slot_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        idx_d    = idx_q;
        acc      = z_valid & z_ready;
        xfer     = s_valid_q & s_ready;
        last     = xfer & (idx_q == IW'(NWO - 1));
        ovf_d    = ovf_q | (z_valid & ~z_ready);
`ifdef WC_SER_CKSUM_EN
        cksum_d  = cksum_q;
        z_x      = '0;
        for (int k = 0; k < NW; k++) z_x = z_x ^ z_in[k*DW +: DW];
`endif
        if (acc) begin
            slot_d[wr_ptr_q] = z_in;
            wr_ptr_d         = ~wr_ptr_q;
`ifdef WC_SER_CKSUM_EN
            cksum_d[wr_ptr_q] = z_x;
`endif
        end
        if (xfer) idx_d = last ? '0 : idx_q + 1'b1;
        if (last) rd_ptr_d = ~rd_ptr_q;
        count_d = count_q + {1'b0, acc} - {1'b0, last};
        for (int k = 0; k < NW; k++) words[k] = slot_d[rd_ptr_d][k*DW +: DW];
`ifdef WC_SER_CKSUM_EN
        words[NW] = cksum_d[rd_ptr_d];
`endif
        s_valid_d = (count_d != 2'd0);
        s_data_d  = s_valid_d ? words[idx_d] : '0;
        s_sof_d   = s_valid_d & (idx_d == '0);
        s_eof_d   = s_valid_d & (idx_d == IW'(NWO - 1));
    end

    // State and registered outputs; asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) slot_q[k] <= '0;
`ifdef WC_SER_CKSUM_EN
            for (int k = 0; k < 2; k++) cksum_q[k] <= '0;
`endif
            count_q   <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            idx_q     <= '0;
            ovf_q     <= 1'b0;
            s_data_q  <= '0;
            s_valid_q <= 1'b0;
            s_sof_q   <= 1'b0;
            s_eof_q   <= 1'b0;
        end else begin
            slot_q    <= slot_d;
`ifdef WC_SER_CKSUM_EN
            cksum_q   <= cksum_d;
`endif
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            idx_q     <= idx_d;
            ovf_q     <= ovf_d;
            s_data_q  <= s_data_d;
            s_valid_q <= s_valid_d;
            s_sof_q   <= s_sof_d;
            s_eof_q   <= s_eof_d;
        end
    end
endmodule

// File: tb/tb_wc_z_serializer.sv
// tb_wc_z_serializer: directed and random stimulus checked against a frame-queue reference model.
module tb_wc_z_serializer;
    localparam int DW = 10;
    localparam int NW = 5;
`ifdef WC_SER_CKSUM_EN
    localparam int NWO = NW + 1;
`else
    localparam int NWO = NW;
`endif
    logic clk = 0, rst = 0;
    logic [DW*NW-1:0] z_in = '0;
    logic z_valid = 0, s_ready = 0;
    logic z_ready, s_valid, s_sof, s_eof, ovf;
    logic [DW-1:0] s_data;
    int total = 0, bad = 0;
    logic [DW*NW-1:0] frames [$];
    int pos = 0;
    bit ovf_m = 0;

    wc_z_serializer #(.DW(DW), .NW(NW)) dut (
        .clk(clk), .rst(rst), .z_in(z_in), .z_valid(z_valid), .z_ready(z_ready),
        .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof), .s_eof(s_eof),
        .s_ready(s_ready), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW*NW-1:0] mk(input int w0, input int w1, input int w2, input int w3, input int w4);
        return {DW'(w4), DW'(w3), DW'(w2), DW'(w1), DW'(w0)};
    endfunction

    function automatic logic [DW-1:0] exp_word(input logic [DW*NW-1:0] f, input int p);
        logic [DW-1:0] x = '0;
        if (p < NW) return f[p*DW +: DW];
        for (int k = 0; k < NW; k++) x = x ^ f[k*DW +: DW];
        return x;
    endfunction

    task automatic check_outputs();
        bit v = frames.size() > 0;
        chk("z_ready", z_ready, frames.size() != 2);
        chk("s_valid", s_valid, v);
        chk("ovf", ovf, ovf_m);
        if (v) begin
            chk("s_data", s_data, exp_word(frames[0], pos));
            chk("s_sof", s_sof, pos == 0);
            chk("s_eof", s_eof, pos == NWO - 1);
        end
    endtask

    task automatic step(input bit zv, input logic [DW*NW-1:0] zd, input bit sr);
        bit acc, xf;
        @(negedge clk);
        check_outputs();
        z_valid = zv;
        z_in    = zd;
        s_ready = sr;
        @(posedge clk);
        acc = zv && frames.size() != 2;
        xf  = frames.size() > 0 && sr;
        if (zv && !acc) ovf_m = 1;
        if (xf) begin
            pos++;
            if (pos == NWO) begin
                void'(frames.pop_front());
                pos = 0;
            end
        end
        if (acc) frames.push_back(zd);
    endtask

    task automatic idle(input int n, input bit sr);
        for (int i = 0; i < n; i++) step(0, '0, sr);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 0;
        #1;
        chk("rst_s_valid", s_valid, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_z_ready", z_ready, 1);
        chk("rst_s_sof", s_sof, 0);
        frames.delete();
        pos = 0;
        ovf_m = 0;
        @(negedge clk);
        rst = 1;
    endtask

    initial begin
        #1;
        chk("init_s_valid", s_valid, 0);
        chk("init_s_data", s_data, 0);
        chk("init_z_ready", z_ready, 1);
        chk("init_ovf", ovf, 0);
        #12 rst = 1;
        // single frame, free-running sink
        step(1, mk(1, 2, 3, 4, 5), 1);
        idle(NWO + 2, 1);
        // three frames offered with sink stalled; third dropped
        step(1, mk(1, 2, 3, 4, 5), 0);
        step(1, mk(6, 7, 8, 9, 10), 0);
        step(1, mk(11, 12, 13, 14, 15), 0);
        idle(2 * NWO + 2, 1);
        // toggling sink readiness
        step(1, mk('h3FF, 0, 'h155, 'h2AA, 7), 1);
        for (int i = 0; i < 2 * NWO + 2; i++) step(0, '0, i % 2 == 0);
        // full buffer, new frame offered on last-word transfer, then retried
        pulse_reset();
        step(1, mk(1, 1, 1, 1, 1), 0);
        step(1, mk(2, 2, 2, 2, 2), 0);
        idle(NWO - 1, 1);
        step(1, mk(3, 3, 3, 3, 3), 1);
        step(1, mk(3, 3, 3, 3, 3), 1);
        idle(2 * NWO + 2, 1);
        // reset mid-frame, then restart from sof
        step(1, mk(4, 4, 4, 4, 4), 1);
        idle(2, 1);
        pulse_reset();
        step(1, mk(9, 9, 9, 9, 9), 1);
        idle(NWO + 1, 1);
        // checksum frame (plain frame when the option is off)
        step(1, mk(1, 2, 4, 8, 16), 1);
        idle(NWO + 1, 1);
        // random traffic
        pulse_reset();
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) == 0, {$urandom, $urandom}, $urandom_range(0, 9) < 7);
        idle(2 * NWO + 4, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
